// File: rtl/pulse_meter_pkg.sv
// Shared types for the pulse interval meter.
// State encoding and the saturating all-ones value.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_e;

  function automatic logic [31:0] sat_max(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF
                         : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/pulse_interval_meter_if.sv
// Control and result bundle of the pulse interval meter.
// master drives controls and the pulse stream; slave is the meter.
interface pulse_interval_meter_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             clear;
  logic             pulse_in;
  logic [WIDTH-1:0] timeout_count;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             overflow;
  logic             timeout;
  logic [WIDTH-1:0] min_period;
  logic [WIDTH-1:0] max_period;
  logic [WIDTH-1:0] sample_count;
  logic             busy;

  modport master (
    output en, clear, pulse_in, timeout_count,
    input  period, period_valid, overflow, timeout,
    input  min_period, max_period, sample_count, busy
  );

  modport slave (
    input  en, clear, pulse_in, timeout_count,
    output period, period_valid, overflow, timeout,
    output min_period, max_period, sample_count, busy
  );
endinterface

// File: rtl/edge_rise_detect.sv
// One-flop rising-edge detector; the flop resets high so a
// level already asserted when reset releases is not an edge.
module edge_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic level_d;
  logic level_q;

  always_comb level_d = d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b1;
    else        level_q <= level_d;
  end

  assign rise = d & ~level_q;

endmodule

// File: rtl/pulse_interval_meter.sv
// Measures cycles between rising edges of pulse_in, keeping
// min/max/count statistics and a programmable missing-pulse timeout.
module pulse_interval_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  pulse_interval_meter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] elapsed_q, elapsed_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             rise;
  logic             tmo_hit;

  edge_rise_detect u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.pulse_in),
    .rise (rise)
  );

  assign tmo_hit = (bus.timeout_count != '0)
                && (elapsed_q == bus.timeout_count);

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    ovf_d     = 1'b0;
    tmo_d     = 1'b0;
    if (!bus.en) begin
      state_d   = IDLE;
      elapsed_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (rise) begin
            state_d   = MEASURE;
            elapsed_d = ONE;
          end
        end
        MEASURE: begin
          // An edge on the timeout cycle still counts as a period.
          if (rise) begin
            valid_d   = 1'b1;
            period_d  = elapsed_q;
            ovf_d     = (elapsed_q == MAX);
            elapsed_d = ONE;
          end else if (tmo_hit) begin
            tmo_d     = 1'b1;
            state_d   = ARMED;
            elapsed_d = '0;
          end else if (elapsed_q != MAX) begin
            elapsed_d = elapsed_q + ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    if (bus.clear && valid_q) begin
      min_d   = period_q;
      max_d   = period_q;
      count_d = ONE;
    end else if (bus.clear) begin
      min_d   = MAX;
      max_d   = '0;
      count_d = '0;
    end else if (valid_q) begin
      if (period_q < min_q) min_d = period_q;
      if (period_q > max_q) max_d = period_q;
      if (count_q != MAX)   count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      min_q     <= MAX;
      max_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      min_q     <= min_d;
      max_q     <= max_d;
      count_q   <= count_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.overflow     = ovf_q;
  assign bus.timeout      = tmo_q;
  assign bus.min_period   = min_q;
  assign bus.max_period   = max_q;
  assign bus.sample_count = count_q;
  assign bus.busy         = (state_q == MEASURE);

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Bench for pulse_interval_meter: directed scenarios on 16- and
// 4-bit instances plus a random stream against a timestamp model.
module tb_pulse_interval_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic        pulse = 1'b0;
  logic [15:0] tc = 16'd0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pulse_interval_meter_if #(.WIDTH(16)) i16 ();
  pulse_interval_meter_if #(.WIDTH(4))  i4 ();

  assign i16.en = en;
  assign i16.clear = clear;
  assign i16.pulse_in = pulse;
  assign i16.timeout_count = tc;
  assign i4.en = en;
  assign i4.clear = clear;
  assign i4.pulse_in = pulse;
  assign i4.timeout_count = tc[3:0];

  pulse_interval_meter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(i16.slave)
  );
  pulse_interval_meter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(i4.slave)
  );

  // Reference: intervals are differences of edge timestamps.
  typedef struct packed {
    logic        prev;
    logic [1:0]  mode;   // 0 idle, 1 armed, 2 measuring
    int          start;
    logic [15:0] period;
    logic        pv;
    logic        ovf;
    logic        to;
    logic [15:0] minp;
    logic [15:0] maxp;
    logic [15:0] cnt;
  } model_t;

  function automatic model_t model_reset(input logic [15:0] maxv);
    model_t r;
    r = '0;
    r.prev = 1'b1;
    r.minp = maxv;
    return r;
  endfunction

  function automatic model_t model_step(
    input model_t m, input logic e, input logic c, input logic p,
    input logic [15:0] t, input logic [15:0] maxv, input int n);
    model_t r;
    logic   rise;
    int     gap;
    r = m;
    rise = p && !m.prev;
    r.prev = p;
    if (c) begin
      r.minp = m.pv ? m.period : maxv;
      r.maxp = m.pv ? m.period : 16'd0;
      r.cnt  = m.pv ? 16'd1 : 16'd0;
    end else if (m.pv) begin
      if (m.period < m.minp) r.minp = m.period;
      if (m.period > m.maxp) r.maxp = m.period;
      if (m.cnt != maxv) r.cnt = m.cnt + 16'd1;
    end
    r.pv = 1'b0;
    r.ovf = 1'b0;
    r.to = 1'b0;
    gap = n - m.start;
    if (!e) r.mode = 2'd0;
    else if (m.mode == 2'd0) r.mode = 2'd1;
    else if (m.mode == 2'd1) begin
      if (rise) begin r.mode = 2'd2; r.start = n; end
    end else if (rise) begin
      r.pv = 1'b1;
      r.ovf = (gap >= int'(maxv));
      r.period = r.ovf ? maxv : 16'(gap);
      r.start = n;
    end else if (t != 16'd0 && gap == int'(t)) begin
      r.to = 1'b1;
      r.mode = 2'd1;
    end
    return r;
  endfunction

  model_t m16, m4;
  int     cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16 <= model_reset(16'hFFFF);
      m4  <= model_reset(16'd15);
      cyc <= 0;
    end else begin
      m16 <= model_step(m16, en, clear, pulse, tc, 16'hFFFF, cyc);
      m4  <= model_step(m4, en, clear, pulse, {12'd0, tc[3:0]},
                        16'd15, cyc);
      cyc <= cyc + 1;
    end
  end

  // Strobe monitor, sampled mid-cycle.
  int          n_pv16 = 0;
  int          n_to16 = 0;
  int          n_pv4 = 0;
  logic [15:0] pq16[$];
  logic [4:0]  pq4[$];

  always @(negedge clk) begin
    if (i16.period_valid) begin
      n_pv16 <= n_pv16 + 1;
      pq16.push_back(i16.period);
    end
    if (i16.timeout) n_to16 <= n_to16 + 1;
    if (i4.period_valid) begin
      n_pv4 <= n_pv4 + 1;
      pq4.push_back({i4.overflow, i4.period});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_then_low(input int low);
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    repeat (low) tick();
  endtask

  task automatic prep(input logic [15:0] t);
    en = 1'b0;
    pulse = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tc = t;
    tick();
    en = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    pulse = 1'b1;
    en = 1'b1;
    #12;
    checks++;
    if ({i16.period, i16.period_valid, i16.overflow, i16.timeout,
         i16.min_period, i16.max_period, i16.sample_count, i16.busy}
        !== {16'h0, 3'b000, 16'hFFFF, 16'h0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset16: period=%h min=%h max=%h cnt=%h busy=%b",
               i16.period, i16.min_period, i16.max_period,
               i16.sample_count, i16.busy);
    end
    checks++;
    if ({i4.min_period, i4.max_period, i4.sample_count, i4.busy}
        !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset4: min=%h max=%h cnt=%h busy=%b",
               i4.min_period, i4.max_period, i4.sample_count, i4.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (i16.busy !== 1'b0 || n_pv16 != 0) begin
      errors++;
      $display("FAIL held_from_reset: busy=%b pv=%0d want 0 0",
               i16.busy, n_pv16);
    end
    pulse = 1'b0;
  endtask

  task automatic test_periodic();
    int b;
    prep(16'd0);
    b = n_pv16;
    repeat (5) edge_then_low(9);
    checks++;
    if (n_pv16 - b != 4) begin
      errors++;
      $display("FAIL periodic_count: got %0d want 4", n_pv16 - b);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pq16[b + k] !== 16'd10) begin
        errors++;
        $display("FAIL periodic_period[%0d]: got %0d want 10",
                 k, pq16[b + k]);
      end
    end
    checks++;
    if ({i16.min_period, i16.max_period, i16.sample_count}
        !== {16'd10, 16'd10, 16'd4}) begin
      errors++;
      $display("FAIL periodic_stats: min=%0d max=%0d cnt=%0d want 10 10 4",
               i16.min_period, i16.max_period, i16.sample_count);
    end
  endtask

  task automatic test_jitter();
    int          b;
    logic [15:0] want[3];
    want = '{16'd7, 16'd12, 16'd9};
    prep(16'd0);
    b = n_pv16;
    edge_then_low(6);
    edge_then_low(11);
    edge_then_low(8);
    edge_then_low(3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pq16[b + k] !== want[k]) begin
        errors++;
        $display("FAIL jitter_period[%0d]: got %0d want %0d",
                 k, pq16[b + k], want[k]);
      end
    end
    checks++;
    if ({i16.min_period, i16.max_period, i16.sample_count}
        !== {16'd7, 16'd12, 16'd3}) begin
      errors++;
      $display("FAIL jitter_stats: min=%0d max=%0d cnt=%0d want 7 12 3",
               i16.min_period, i16.max_period, i16.sample_count);
    end
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    tick();
    tick();
    checks++;
    if ({i16.min_period, i16.max_period, i16.sample_count}
        !== {16'd5, 16'd5, 16'd1}) begin
      errors++;
      $display("FAIL clear_stats: min=%0d max=%0d cnt=%0d want 5 5 1",
               i16.min_period, i16.max_period, i16.sample_count);
    end
    repeat (5) tick();
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    checks++;
    if ({i16.min_period, i16.max_period, i16.sample_count}
        !== {16'd8, 16'd8, 16'd1}) begin
      errors++;
      $display("FAIL clear_coincident: min=%0d max=%0d cnt=%0d want 8 8 1",
               i16.min_period, i16.max_period, i16.sample_count);
    end
  endtask

  task automatic test_timeout();
    int b;
    int bt;
    int k;
    prep(16'd20);
    b = n_pv16;
    bt = n_to16;
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    k = 0;
    while (i16.timeout !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    checks++;
    if (k != 20) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles want 20", k);
    end
    tick();
    checks++;
    if (i16.timeout !== 1'b0 || i16.busy !== 1'b0
        || n_to16 - bt != 1 || n_pv16 != b) begin
      errors++;
      $display("FAIL timeout_strobe: to=%b busy=%b n_to=%0d n_pv=%0d",
               i16.timeout, i16.busy, n_to16 - bt, n_pv16 - b);
    end
    edge_then_low(5);
    edge_then_low(2);
    checks++;
    if (n_pv16 - b != 1 || pq16[b] !== 16'd6) begin
      errors++;
      $display("FAIL timeout_rearm: n=%0d period=%0d want 1 6",
               n_pv16 - b, pq16[b]);
    end
  endtask

  task automatic test_saturation();
    int b;
    prep(16'd0);
    b = n_pv4;
    edge_then_low(29);
    edge_then_low(2);
    edge_then_low(3);
    checks++;
    if (n_pv4 - b != 2 || pq4[b] !== 5'h1F) begin
      errors++;
      $display("FAIL sat_overflow: n=%0d ovf_period=%h want 2 1f",
               n_pv4 - b, pq4[b]);
    end
    checks++;
    if (pq4[b + 1] !== 5'h03) begin
      errors++;
      $display("FAIL sat_recover: ovf_period=%h want 03", pq4[b + 1]);
    end
    checks++;
    if ({i4.min_period, i4.max_period, i4.sample_count}
        !== {4'd3, 4'd15, 4'd2}) begin
      errors++;
      $display("FAIL sat_stats: min=%0d max=%0d cnt=%0d want 3 15 2",
               i4.min_period, i4.max_period, i4.sample_count);
    end
  endtask

  task automatic test_held();
    int b;
    int bt;
    prep(16'd0);
    b = n_pv16;
    pulse = 1'b1;
    repeat (8) tick();
    pulse = 1'b0;
    repeat (4) tick();
    checks++;
    if (n_pv16 != b || i16.busy !== 1'b1) begin
      errors++;
      $display("FAIL held_level: n_pv=%0d busy=%b want 0 1",
               n_pv16 - b, i16.busy);
    end
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    tc = 16'd6;
    repeat (5) tick();
    bt = n_to16;
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    tick();
    tick();
    checks++;
    if (n_pv16 - b != 2 || pq16[b] !== 16'd12 || pq16[b + 1] !== 16'd6) begin
      errors++;
      $display("FAIL held_periods: n=%0d p0=%0d p1=%0d want 2 12 6",
               n_pv16 - b, pq16[b], pq16[b + 1]);
    end
    checks++;
    if (n_to16 != bt) begin
      errors++;
      $display("FAIL edge_beats_timeout: timeouts=%0d want 0", n_to16 - bt);
    end
  endtask

  task automatic test_enable_reset();
    int b;
    prep(16'd0);
    b = n_pv16;
    edge_then_low(3);
    edge_then_low(2);
    en = 1'b0;
    tick();
    checks++;
    if ({i16.busy, i16.period_valid, i16.timeout} !== 3'b000) begin
      errors++;
      $display("FAIL en_drop: busy=%b pv=%b to=%b want 000",
               i16.busy, i16.period_valid, i16.timeout);
    end
    edge_then_low(2);
    edge_then_low(2);
    checks++;
    if (n_pv16 - b != 1 || {i16.period, i16.min_period, i16.max_period,
        i16.sample_count} !== {16'd4, 16'd4, 16'd4, 16'd1}) begin
      errors++;
      $display("FAIL en_retain: n=%0d p=%0d min=%0d max=%0d cnt=%0d",
               n_pv16 - b, i16.period, i16.min_period,
               i16.max_period, i16.sample_count);
    end
    en = 1'b1;
    tick();
    tick();
    edge_then_low(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i16.period, i16.period_valid, i16.overflow, i16.timeout,
         i16.min_period, i16.max_period, i16.sample_count, i16.busy}
        !== {16'h0, 3'b000, 16'hFFFF, 16'h0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: period=%h min=%h max=%h cnt=%h busy=%b",
               i16.period, i16.min_period, i16.max_period,
               i16.sample_count, i16.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int gap_left;
    int hold;
    gap_left = 3;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold > 0) begin
        pulse = 1'b1;
        hold--;
      end else if (gap_left > 0) begin
        pulse = 1'b0;
        gap_left--;
      end else begin
        pulse = 1'b1;
        hold = int'($urandom_range(0, 2));
        gap_left = int'($urandom_range(1, 40));
      end
      clear = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 199) == 0)
        tc = ($urandom_range(0, 2) == 0) ? 16'd0
                                         : 16'($urandom_range(2, 25));
      tick();
      checks++;
      if ({i16.period, i16.period_valid, i16.overflow, i16.timeout,
           i16.min_period, i16.max_period, i16.sample_count, i16.busy}
          !== {m16.period, m16.pv, m16.ovf, m16.to, m16.minp,
               m16.maxp, m16.cnt, m16.mode == 2'd2}) begin
        errors++;
        $display("FAIL random16 cyc %0d: p=%0d pv=%b to=%b cnt=%0d want p=%0d pv=%b to=%b cnt=%0d",
                 i, i16.period, i16.period_valid, i16.timeout,
                 i16.sample_count, m16.period, m16.pv, m16.to, m16.cnt);
      end
      checks++;
      if ({i4.period, i4.period_valid, i4.overflow, i4.timeout,
           i4.min_period, i4.max_period, i4.sample_count, i4.busy}
          !== {m4.period[3:0], m4.pv, m4.ovf, m4.to, m4.minp[3:0],
               m4.maxp[3:0], m4.cnt[3:0], m4.mode == 2'd2}) begin
        errors++;
        $display("FAIL random4 cyc %0d: p=%0d ovf=%b to=%b min=%0d want p=%0d ovf=%b to=%b min=%0d",
                 i, i4.period, i4.overflow, i4.timeout, i4.min_period,
                 m4.period, m4.ovf, m4.to, m4.minp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_jitter();
    test_timeout();
    test_saturation();
    test_held();
    test_enable_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_interval_meter.md
# pulse_interval_meter

Measures the spacing, in `clk` cycles, between consecutive rising edges of a pulse stream, such as the single-cycle pulses from the team's general-purpose up-counter. On each interval it reports the period and keeps running minimum and maximum values. It can also flag a missing pulse via a programmable timeout. The block sits on the receiving side of pulse-generating timers and is used for rate checking and period self-test.

## Interface
- `WIDTH`, 16: width of the elapsed counter and of all period outputs.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: measurement enable. Low forces IDLE.
- `clear` input 1: synchronous clear of the statistics (`min_period`, `max_period`, `sample_count`).
- `pulse_in` input 1: synchronous pulse stream. Only rising edges count; a held-high level counts once.
- `timeout_count` input WIDTH: the elapsed count that raises a timeout. 0 disables the timeout.
- `period` output WIDTH: most recent measured interval. Holds until the next measurement.
- `period_valid` output 1: single-cycle strobe that `period` was just updated.
- `overflow` output 1: qualifies `period_valid`; set when the interval saturated at all-ones.
- `timeout` output 1: single-cycle strobe; expected edge not seen within `timeout_count` cycles.
- `min_period` output WIDTH: smallest period since the last clear.
- `max_period` output WIDTH: largest period since the last clear.
- `sample_count` output WIDTH: number of periods since the last clear. Saturates at all-ones.
- `busy` output 1: high in MEASURE.

## Operation
- Edge detect uses a single register `pulse_q`; the event is `pulse_in & ~pulse_q`. `pulse_q` resets to 1, so a pulse held high out of reset is not counted.
- States:
  - IDLE: entered when `en`=0. Elapsed counter is held at 0.
  - ARMED: `en`=1, waiting for the first edge.
  - MEASURE: counting the interval.
- Transitions:
  - IDLE→ARMED: `en`=1.
  - ARMED→MEASURE: on an edge. Elapsed is loaded with 1.
  - MEASURE→MEASURE: on an edge. Report elapsed as `period`, reload elapsed with 1.
  - MEASURE→ARMED: on timeout.
  - Any state→IDLE: `en`=0 (takes priority over everything).
- Elapsed counter increments every MEASURE cycle and saturates at 2^WIDTH−1; it never wraps. An edge while saturated reports all-ones with `overflow`=1.
- Timeout fires when `timeout_count`≠0 and elapsed equals `timeout_count` with no edge in that cycle. It pulses `timeout`, produces no `period_valid`, and returns to ARMED.
- Edge and timeout in the same cycle: the edge wins and the period is reported.
- Statistics update on each `period_valid`:
  - `min_period` ← min(`min_period`, `period`). Reset/clear value is all-ones.
  - `max_period` ← max(`max_period`, `period`). Reset/clear value is 0.
  - `sample_count` increments by 1.
- `clear` coincident with `period_valid`: statistics load from the new sample. `min_period` = `max_period` = `period`, `sample_count` = 1.
- `en` dropped mid-interval: the partial interval is discarded, with no strobe. Statistics are retained.
- Reset values: state IDLE; `period` 0; `period_valid`, `overflow`, `timeout`, `busy` all 0; `min_period` all-ones; `max_period` 0; `sample_count` 0.

## Timing
- An edge sampled at clock edge t produces `period_valid` high during cycle t+1, i.e. one cycle of latency.
- Edges sampled at t0 and t1 give `period` = t1 − t0. Pulses every N cycles report N.
- Minimum measurable period is 2, since a one-cycle gap is required to re-detect a rising edge.
- Statistics are visible in the cycle after `period_valid`.
- Timeout: the first edge at t0 with `timeout_count`=T gives `timeout` high during cycle t0+T+1.
- `clear` takes effect at the next clock edge.
- `en` low at edge t: `busy`=0 from cycle t+1. No strobes occur in that cycle.

## Structure
- Shared package `pulse_meter_pkg` holds the state enum (IDLE/ARMED/MEASURE) and the saturating all-ones constant as a function of WIDTH.
- One sub-module: `edge_rise_detect`, the 1-flop rising-edge detector with a reset-to-1 register. It is reusable by other pulse consumers.
- Everything else, including the FSM, elapsed counter and statistics, is in the top module.

## Test plan
- Periodic stream: WIDTH=16, pulse every 10 cycles, 5 edges. Expect 4 `period_valid` with `period`=10. `min_period` = `max_period` = 10, `sample_count`=4.
- Jitter: edge gaps 7, 12, 9. Expect `period` 7, 12, 9; `min_period`=7, `max_period`=12, `sample_count`=3. `clear` then gap 5 gives min = max = 5, count 1.
- Timeout: `timeout_count`=20, single edge, no more. Expect `timeout` for one cycle, 21 cycles after the edge sample. The next two edges 6 apart report `period`=6.
- Saturation: WIDTH=4, `timeout_count`=0, gap of 30 cycles. Expect `period`=15 with `overflow`=1. A following gap of 3 reports 3 with `overflow`=0.
- Held level and simultaneity: `pulse_in` high for 8 cycles counts as one edge. With `timeout_count`=6, an edge exactly 6 cycles later reports `period`=6 and no `timeout`.
- Reset and enable: deassert `rst_n` asynchronously mid-MEASURE, so that all outputs take their reset values immediately. Dropping `en` mid-interval gives no strobe and statistics are retained.
